fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle RISC-V core, sitting directly upstream of the control unit and decode. It holds the PC, issues one request at a time to a variable-latency instruction memory, and registers the returned instruction with a valid/ready handshake. The opcode, fun3 and fun7 fields of that instruction drive the control unit. The block consumes `pc_src` and the sign-extended immediate back from execute to redirect on taken branches, and it halts on a misaligned target.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the single-cycle RISC-V core.
// Holds the PC, issues one request at a time to a variable-latency
// instruction memory, registers the returned word for decode/control behind
// a valid/ready handshake, and redirects on taken branches. A misaligned
// target sets a sticky error and halts fetch until reset.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   imem_req/addr      - one-cycle request pulse and fetch address
//   imem_rvalid/rdata  - memory response (only sampled while waiting)
//   instr, instr_pc    - registered instruction and its address
//   instr_valid/ready  - handshake towards execute
//   pc_src, imm_ext    - branch-taken flag and sign-extended offset
//   fetch_misaligned   - sticky misaligned-target error
//   instret            - count of accepted instructions (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic        fetch_misaligned,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] next_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
      instret_q     <= instret_d;
    end
  end

  // Redirect target resolved in the accepting cycle, so nothing is ever
  // fetched down the wrong path.
  assign next_pc = pc_src ? (instr_pc_q + imm_ext) : (instr_pc_q + 32'd4);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = misaligned_q;
    instret_d     = instret_q;
    case (state_q)
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          state_d       = S_FULL;
        end
      end
      S_FULL: begin
        if (instr_ready) begin
          instret_d     = instret_q + 32'd1;
          instr_valid_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = S_HALT;
          end else begin
            fetch_pc_d = next_pc;
            state_d    = S_REQ;
          end
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Reset parks the FSM in REQ, so the request is masked while reset is held
  // to keep it low until the first cycle after release.
  assign imem_req         = (state_q == S_REQ) & ~reset;
  assign imem_addr        = fetch_pc_q;
  assign instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign instr_valid      = instr_valid_q;
  assign fetch_misaligned = misaligned_q;
  assign instret          = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_src;
  logic [31:0] imm_ext;
  logic        fetch_misaligned;
  logic [31:0] instret;

  int total;
  int passed;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .pc_src          (pc_src),
    .imm_ext         (imm_ext),
    .fetch_misaligned(fetch_misaligned),
    .instret         (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: request seen in cycle t answers in cycle t+lat.
  logic [31:0] mem [0:15];
  int          lat;
  int          pending;
  logic        auto_rvalid;
  logic [31:0] auto_rdata;
  logic [31:0] req_addr;
  logic        man_rvalid;
  logic [31:0] man_rdata;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      pending     = 0;
      auto_rvalid = 1'b0;
      auto_rdata  = 32'h0;
    end else begin
      auto_rvalid = 1'b0;
      if (pending > 0) begin
        pending = pending - 1;
        if (pending == 0) begin
          auto_rvalid = 1'b1;
          auto_rdata  = mem[req_addr[5:2]];
        end
      end
      if (imem_req) begin
        pending  = lat;
        req_addr = imem_addr;
      end
    end
  end

  assign imem_rvalid = auto_rvalid | man_rvalid;
  assign imem_rdata  = man_rvalid ? man_rdata : auto_rdata;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instr_ready = 1'b0;
    pc_src      = 1'b1;
    imm_ext     = 32'h0000_0002;
    man_rvalid  = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  // One-cycle accept; idle values of pc_src/imm_ext are deliberately hostile.
  task automatic accept(input logic src, input logic [31:0] imm);
    instr_ready = 1'b1;
    pc_src      = src;
    imm_ext     = imm;
    tick();
    instr_ready = 1'b0;
    pc_src      = 1'b1;
    imm_ext     = 32'h0000_0002;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 00000000", imem_addr); else passed++;
    total++; if (instr !== 32'h0000_0013) $display("FAIL rst_instr: got %h expected 00000013", instr); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h expected 00000000", instr_pc); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", instr_valid); else passed++;
    total++; if (fetch_misaligned !== 1'b0) $display("FAIL rst_mis: got %b expected 0", fetch_misaligned); else passed++;
    total++; if (instret !== 32'h0) $display("FAIL rst_instret: got %h expected 00000000", instret); else passed++;
    lat = 2;
    do_reset();
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL rst_first_req: got %b expected 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rst_first_addr: got %h expected 00000000", imem_addr); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] words [0:2];
    logic        exp_req;
    logic        exp_valid;
    int          k;
    words[0] = 32'h0050_0093;
    words[1] = 32'h0010_0113;
    words[2] = 32'h0020_81B3;
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    pc_src      = 1'b0;
    imm_ext     = 32'h0;
    for (int c = 0; c < 9; c++) begin
      tick();
      k         = c / 3;
      exp_req   = (c % 3 == 0);
      exp_valid = (c % 3 == 2);
      total++; if (imem_req !== exp_req) $display("FAIL seq_req c=%0d: got %b expected %b", c, imem_req, exp_req); else passed++;
      if (exp_req) begin
        total++; if (imem_addr !== 32'(4 * k)) $display("FAIL seq_addr c=%0d: got %h expected %h", c, imem_addr, 32'(4 * k)); else passed++;
      end
      total++; if (instr_valid !== exp_valid) $display("FAIL seq_valid c=%0d: got %b expected %b", c, instr_valid, exp_valid); else passed++;
      if (exp_valid) begin
        total++; if (instr !== words[k]) $display("FAIL seq_instr c=%0d: got %h expected %h", c, instr, words[k]); else passed++;
        total++; if (instr_pc !== 32'(4 * k)) $display("FAIL seq_pc c=%0d: got %h expected %h", c, instr_pc, 32'(4 * k)); else passed++;
      end
    end
    tick();
    total++; if (instret !== 32'd3) $display("FAIL seq_instret: got %0d expected 3", instret); else passed++;
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    int c;
    lat = 3;
    do_reset();
    tick();
    c = 0;
    while (!instr_valid && c < 20) begin
      tick();
      c++;
    end
    total++; if (c !== 4) $display("FAIL stall_latency: got cycle %0d expected 4", c); else passed++;
    for (int i = 0; i < 5; i++) begin
      total++; if (instr !== 32'h0050_0093) $display("FAIL stall_instr i=%0d: got %h expected 00500093", i, instr); else passed++;
      total++; if (instr_pc !== 32'h0) $display("FAIL stall_pc i=%0d: got %h expected 00000000", i, instr_pc); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL stall_req i=%0d: got %b expected 0", i, imem_req); else passed++;
      total++; if (instr_valid !== 1'b1) $display("FAIL stall_valid i=%0d: got %b expected 1", i, instr_valid); else passed++;
      if (i < 4) tick();
    end
    accept(1'b0, 32'h0);
    total++; if (imem_req !== 1'b1) $display("FAIL stall_next_req: got %b expected 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h4) $display("FAIL stall_next_addr: got %h expected 00000004", imem_addr); else passed++;
    total++; if (instret !== 32'd1) $display("FAIL stall_instret: got %0d expected 1", instret); else passed++;
  endtask

  task automatic test_branch();
    lat = 1;
    do_reset();
    wait_valid(); accept(1'b0, 32'h0);
    wait_valid(); accept(1'b0, 32'h0);
    wait_valid();
    total++; if (instr_pc !== 32'h8) $display("FAIL br_pc8: got %h expected 00000008", instr_pc); else passed++;
    accept(1'b1, 32'hFFFF_FFF8);
    total++; if (imem_req !== 1'b1) $display("FAIL br_taken_req: got %b expected 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL br_taken_addr: got %h expected 00000000", imem_addr); else passed++;
    wait_valid();
    total++; if (instr_pc !== 32'h0) $display("FAIL br_target_pc: got %h expected 00000000", instr_pc); else passed++;
    accept(1'b0, 32'h0);
    wait_valid(); accept(1'b0, 32'h0);
    wait_valid();
    accept(1'b0, 32'hFFFF_FFF8);
    total++; if (imem_addr !== 32'hC) $display("FAIL br_not_taken_addr: got %h expected 0000000c", imem_addr); else passed++;
    wait_valid();
    accept(1'b1, 32'hFFFF_FFF0);
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL br_neg_addr: got %h expected fffffffc", imem_addr); else passed++;
    wait_valid();
    total++; if (instr !== 32'hA000_000F) $display("FAIL br_top_instr: got %h expected a000000f", instr); else passed++;
    total++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL br_top_pc: got %h expected fffffffc", instr_pc); else passed++;
    accept(1'b0, 32'h0);
    total++; if (imem_req !== 1'b1) $display("FAIL wrap_req: got %b expected 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr: got %h expected 00000000", imem_addr); else passed++;
    total++; if (fetch_misaligned !== 1'b0) $display("FAIL wrap_mis: got %b expected 0", fetch_misaligned); else passed++;
    total++; if (instret !== 32'd8) $display("FAIL br_instret: got %0d expected 8", instret); else passed++;
  endtask

  task automatic test_misaligned();
    int reqs;
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      accept(1'b0, 32'h0);
    end
    wait_valid();
    total++; if (instr_pc !== 32'h10) $display("FAIL mis_pc: got %h expected 00000010", instr_pc); else passed++;
    accept(1'b1, 32'h6);
    total++; if (fetch_misaligned !== 1'b1) $display("FAIL mis_flag: got %b expected 1", fetch_misaligned); else passed++;
    total++; if (instret !== 32'd5) $display("FAIL mis_instret: got %0d expected 5", instret); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL mis_valid: got %b expected 0", instr_valid); else passed++;
    instr_ready = 1'b1;
    man_rdata   = 32'hBAD0_BAD0;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      man_rvalid = (i % 2 == 0);
      if (imem_req) reqs++;
      tick();
    end
    man_rvalid  = 1'b0;
    instr_ready = 1'b0;
    total++; if (reqs !== 0) $display("FAIL halt_reqs: got %0d expected 0", reqs); else passed++;
    total++; if (imem_addr !== 32'h10) $display("FAIL halt_addr: got %h expected 00000010", imem_addr); else passed++;
    total++; if (instret !== 32'd5) $display("FAIL halt_instret: got %0d expected 5", instret); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL halt_valid: got %b expected 0", instr_valid); else passed++;
    total++; if (fetch_misaligned !== 1'b1) $display("FAIL halt_sticky: got %b expected 1", fetch_misaligned); else passed++;
    do_reset();
    tick();
    total++; if (fetch_misaligned !== 1'b0) $display("FAIL mis_cleared: got %b expected 0", fetch_misaligned); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL mis_restart_req: got %b expected 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL mis_restart_addr: got %h expected 00000000", imem_addr); else passed++;
  endtask

  task automatic test_async_reset();
    lat = 4;
    do_reset();
    tick(); tick(); tick();
    total++; if (imem_req !== 1'b0) $display("FAIL ar_wait_req: got %b expected 0", imem_req); else passed++;
    reset = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL ar_valid: got %b expected 0", instr_valid); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL ar_addr: got %h expected 00000000", imem_addr); else passed++;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    man_rdata  = 32'hDEAD_BEEF;
    man_rvalid = 1'b1;
    tick();
    total++; if (imem_req !== 1'b1) $display("FAIL ar_req: got %b expected 1", imem_req); else passed++;
    tick();
    man_rvalid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      total++; if (instr_valid !== 1'b0) $display("FAIL ar_spurious c=%0d: got %b expected 0", c, instr_valid); else passed++;
      tick();
    end
    total++; if (instr_valid !== 1'b1) $display("FAIL ar_resp_valid: got %b expected 1", instr_valid); else passed++;
    total++; if (instr !== 32'h0050_0093) $display("FAIL ar_resp_instr: got %h expected 00500093", instr); else passed++;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    reset       = 1'b1;
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    imm_ext     = 32'h0;
    man_rvalid  = 1'b0;
    man_rdata   = 32'h0;
    lat         = 1;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_81B3;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misaligned();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
